// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
// -------------------
// Registered priority encoder with a valid/ready output handshake.
// MODE=0 picks the highest set request bit. MODE=1 runs a round-robin search
// that starts at an internal pointer and wraps from N-1 back to 0. After each
// capture the pointer moves to one past the winner.
//
// Parameters:
//   N     number of request inputs (N >= 2)
//   W     width of the encoded index, defaults to $clog2(N)
//   MODE  0 = fixed priority, 1 = round-robin
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears out, valid, ptr, err)
//   i      request vector, bit k requests index k
//   en     capture enable
//   ready  downstream accepts the current out/valid pair
//   out    registered winning index
//   valid  out holds an unconsumed result
//   err    (only with ENC_MULTIHOT_ERR_EN) captured request had more than one bit set
//
// Optional feature macro: ENC_MULTIHOT_ERR_EN adds the err port and its detection logic.

module priority_encoder_rr #(
    parameter int N    = 16,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         en,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic         valid
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic         err
`endif
);

    logic         free;
    logic         capture;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] fixed_winner;
    logic [W-1:0] rr_winner;
    logic [W-1:0] winner;
    logic [N-1:0] rot;
    logic [W-1:0] rr_offset;
    logic [W:0]   rr_sum;

    // A result can be replaced when nothing is pending or it is being consumed this cycle.
    assign free    = !valid || ready;
    assign capture = free && en && (i != '0);

    // Fixed priority: scanning upwards lets the highest set bit be the last one written.
    always_comb begin
        fixed_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (i[k]) begin
                fixed_winner = W'(k);
            end
        end
    end

    // Round-robin: rotate the requests so that ptr lands on bit 0.
    // Then find the lowest set bit and add ptr back, modulo N.
    // The sum gets one extra bit so it cannot overflow before the wrap.
    // This keeps the wrap correct when N is not a power of two.
    always_comb begin
        rot       = N'({i, i} >> ptr);
        rr_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_offset = W'(k);
            end
        end
        rr_sum = {1'b0, ptr} + {1'b0, rr_offset};
        if (rr_sum >= (W+1)'(N)) begin
            rr_sum = rr_sum - (W+1)'(N);
        end
        rr_winner = rr_sum[W-1:0];
    end

    assign winner   = (MODE == 1) ? rr_winner : fixed_winner;
    assign ptr_next = (winner == W'(N - 1)) ? '0 : winner + W'(1);

    // Output register and handshake.
    // While a result waits on backpressure, new requests are ignored, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (free) begin
            if (capture) begin
                out   <= winner;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer. In fixed-priority mode it stays at zero and is never consulted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (capture && (MODE == 1)) begin
            ptr <= ptr_next;
        end
    end

`ifdef ENC_MULTIHOT_ERR_EN
    logic multi_hot;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_hot = (i & (i - N'(1))) != '0;

    // err follows the same hold/clear rules as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (free) begin
            if (capture) begin
                err <= multi_hot;
            end else begin
                err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr
// ----------------------
// Drives three encoder instances from the same stimulus:
//   dut0: N=16 fixed priority
//   dut1: N=16 round-robin
//   dut2: N=5  round-robin (non-power-of-two wrap)
// A behavioural model predicts every output each cycle.
// Directed steps also pin hand-computed literal values.

module tb_priority_encoder_rr;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ready;
    logic [15:0] i_bus;

    logic [3:0]  out0;
    logic [3:0]  out1;
    logic [2:0]  out2;
    logic        valid0;
    logic        valid1;
    logic        valid2;
`ifdef ENC_MULTIHOT_ERR_EN
    logic        err0;
    logic        err1;
    logic        err2;
`endif

    int check_count;
    int pass_count;
    bit model_ready;

    int exp_out   [3];
    int exp_valid [3];
    int exp_err   [3];
    int exp_ptr   [3];
    int model_n   [3] = '{16, 16, 5};
    int model_mode[3] = '{0, 1, 1};

    priority_encoder_rr #(.N(16), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .i(i_bus), .en(en), .ready(ready),
        .out(out0), .valid(valid0)
`ifdef ENC_MULTIHOT_ERR_EN
        , .err(err0)
`endif
    );

    priority_encoder_rr #(.N(16), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i(i_bus), .en(en), .ready(ready),
        .out(out1), .valid(valid1)
`ifdef ENC_MULTIHOT_ERR_EN
        , .err(err1)
`endif
    );

    priority_encoder_rr #(.N(5), .MODE(1)) dut2 (
        .clk(clk), .rst(rst), .i(i_bus[4:0]), .en(en), .ready(ready),
        .out(out2), .valid(valid2)
`ifdef ENC_MULTIHOT_ERR_EN
        , .err(err2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Restricts a request word to the n inputs that an instance actually has.
    function automatic int reqMask(input logic [15:0] req, input int n);
        return int'(req) & ((1 << n) - 1);
    endfunction

    // Winner straight from the rules.
    // Fixed mode returns the position of the most significant set bit.
    // Round-robin mode rotates so ptr sits at bit 0, isolates the lowest set bit,
    // and maps it back modulo n.
    function automatic int modelWinner(input int n, input int mode, input int ptr, input int req);
        int rot;
        int low;
        if (mode == 0) begin
            return $clog2(req + 1) - 1;
        end
        rot = ((req >> ptr) | (req << (n - ptr))) & ((1 << n) - 1);
        low = rot & (-rot);
        return (ptr + $clog2(low)) % n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Inputs change on the falling edge; results are readable 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] req, input logic rdy);
        @(negedge clk);
        rst   = r;
        en    = e;
        i_bus = req;
        ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model, advanced on every rising edge from the inputs presented to the DUTs.
    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                exp_out[m]   <= 0;
                exp_valid[m] <= 0;
                exp_err[m]   <= 0;
                exp_ptr[m]   <= 0;
            end else if (exp_valid[m] == 0 || ready) begin
                if (en && reqMask(i_bus, model_n[m]) != 0) begin
                    exp_out[m]   <= modelWinner(model_n[m], model_mode[m], exp_ptr[m], reqMask(i_bus, model_n[m]));
                    exp_valid[m] <= 1;
                    exp_err[m]   <= ($countones(reqMask(i_bus, model_n[m])) > 1) ? 1 : 0;
                    if (model_mode[m] == 1) begin
                        exp_ptr[m] <= (modelWinner(model_n[m], 1, exp_ptr[m], reqMask(i_bus, model_n[m])) + 1) % model_n[m];
                    end
                end else begin
                    exp_valid[m] <= 0;
                    exp_err[m]   <= 0;
                end
            end
        end
        if (rst) begin
            model_ready <= 1'b1;
        end
    end

    // Every cycle after the first reset, compare all instances against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("model out0",   32'(out0),   32'(exp_out[0]));
            checkOutput("model valid0", 32'(valid0), 32'(exp_valid[0]));
            checkOutput("model out1",   32'(out1),   32'(exp_out[1]));
            checkOutput("model valid1", 32'(valid1), 32'(exp_valid[1]));
            checkOutput("model out2",   32'(out2),   32'(exp_out[2]));
            checkOutput("model valid2", 32'(valid2), 32'(exp_valid[2]));
`ifdef ENC_MULTIHOT_ERR_EN
            checkOutput("model err0", 32'(err0), 32'(exp_err[0]));
            checkOutput("model err1", 32'(err1), 32'(exp_err[1]));
            checkOutput("model err2", 32'(err2), 32'(exp_err[2]));
`endif
        end
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        model_ready = 1'b0;
        rst   = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        i_bus = 16'h0000;

        // Reset held for two cycles while requests are asserted.
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1);
        checkOutput("reset out0", 32'(out0), 0);
        checkOutput("reset valid0", 32'(valid0), 0);
        checkOutput("reset valid1", 32'(valid1), 0);
        checkOutput("reset valid2", 32'(valid2), 0);
`ifdef ENC_MULTIHOT_ERR_EN
        checkOutput("reset err0", 32'(err0), 0);
`endif

        // Basic capture, then valid drops when there is no request.
        applyStimulus(1'b0, 1'b1, 16'h0012, 1'b1);
        checkOutput("fixed 0012 out0", 32'(out0), 4);
        checkOutput("fixed 0012 valid0", 32'(valid0), 1);
        checkOutput("rr 0012 out1", 32'(out1), 1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        checkOutput("idle valid0", 32'(valid0), 0);
        checkOutput("idle out0 hold", 32'(out0), 4);

        // Backpressure holds the pending result; the new request waits.
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
        checkOutput("capture 0100 out0", 32'(out0), 8);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 16'h8000, 1'b0);
            checkOutput("stall out0", 32'(out0), 8);
            checkOutput("stall valid0", 32'(valid0), 1);
        end
        applyStimulus(1'b0, 1'b1, 16'h8000, 1'b1);
        checkOutput("release out0", 32'(out0), 15);

        // Reset in the middle of a stalled handshake discards the pending result.
        applyStimulus(1'b1, 1'b1, 16'h8000, 1'b0);
        checkOutput("midrst valid0", 32'(valid0), 0);
        checkOutput("midrst out0", 32'(out0), 0);
        checkOutput("midrst out1", 32'(out1), 0);
        applyStimulus(1'b0, 1'b1, 16'h0400, 1'b1);
        checkOutput("post-rst out0", 32'(out0), 10);
        checkOutput("post-rst out1", 32'(out1), 10);

        // Round-robin alternation between the two ends; the pointer wraps 15 -> 0.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b1);
        checkOutput("rr seq0 out1", 32'(out1), 0);
        checkOutput("rr seq0 out0", 32'(out0), 15);
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b1);
        checkOutput("rr seq1 out1", 32'(out1), 15);
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b1);
        checkOutput("rr seq2 out1", 32'(out1), 0);
        checkOutput("rr seq2 out2", 32'(out2), 0);
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b1);
        checkOutput("rr seq3 out1", 32'(out1), 15);

        // N=5 wrap: winning index 4 sends the pointer back to 0.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1);
        checkOutput("n5 top out2", 32'(out2), 4);
        applyStimulus(1'b0, 1'b1, 16'h0011, 1'b1);
        checkOutput("n5 wrap out2", 32'(out2), 0);

        // Disabled capture with ready high empties the register.
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 1'b1);
        checkOutput("en low valid0", 32'(valid0), 0);

        // Multi-hot versus one-hot capture.
        applyStimulus(1'b0, 1'b1, 16'h0003, 1'b1);
        checkOutput("multihot out0", 32'(out0), 1);
`ifdef ENC_MULTIHOT_ERR_EN
        checkOutput("multihot err0", 32'(err0), 1);
`endif
        applyStimulus(1'b0, 1'b1, 16'h0004, 1'b1);
        checkOutput("onehot out0", 32'(out0), 2);
`ifdef ENC_MULTIHOT_ERR_EN
        checkOutput("onehot err0", 32'(err0), 0);
`endif

        // Mixed traffic, checked against the model only.
        for (int k = 0; k < 200; k++) begin
            applyStimulus($urandom_range(0, 40) == 0,
                          $urandom_range(0, 3) != 0,
                          16'($urandom & $urandom),
                          $urandom_range(0, 2) != 0);
        end

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter N, default 16: number of request inputs; N >= 2.
REQ-002 Parameter W, default $clog2(N) (4): output index width.
REQ-003 Parameter MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port i  input  N: request vector; bit k requests index k.
REQ-007 Port en  input  1: capture enable.
REQ-008 Port ready  input  1: downstream accepts the current out/valid pair.
REQ-009 Port out  output  W: registered encoded index.
REQ-010 Port valid  output  1: out holds an unconsumed result.
REQ-011 Port err  output  1: present only under ENC_MULTIHOT_ERR_EN (REQ-032).

Function
REQ-012 Output register is "free" when valid=0 or ready=1, sampled in the same cycle.
REQ-013 Capture occurs when en=1, the register is free and i != 0; result appears on out/valid at the next rising edge (latency 1 cycle).
REQ-014 On capture: out <= winning index; valid <= 1.
REQ-015 Register free with no capture (en=0 or i=0): valid <= 0; out holds its last value.
REQ-016 valid=1 and ready=0: out and valid hold unchanged regardless of en/i; the request is not latched and must be re-presented.
REQ-017 Simultaneous valid=1, ready=1 and capture: the new index replaces out; valid stays 1 (back-to-back, one result per cycle).
REQ-018 MODE=0: winner is the highest set index in i.
REQ-019 MODE=1: internal pointer ptr (W bits, range 0..N-1); winner is the first set bit searching ascending from ptr inclusive, wrapping N-1 -> 0.
REQ-020 MODE=1: on capture ptr <= winner+1, wrapping to 0 when winner = N-1 (including non-power-of-2 N); ptr unchanged otherwise.
REQ-021 MODE=0: ptr is absent or constant and has no effect.
REQ-022 Non-power-of-2 N: out never exceeds N-1.
REQ-023 Bits of i change freely between cycles; only the value at the capture edge matters.

Reset
REQ-024 rst=1 at a rising edge: out <= 0, valid <= 0, ptr <= 0, err <= 0.
REQ-025 rst has priority over capture and hold, including mid-handshake with valid=1 and ready=0; the pending result is discarded.
REQ-026 First capture is possible at the first edge after rst deasserts.

Configuration
REQ-030 Macro ENC_MULTIHOT_ERR_EN controls the multi-hot error flag.
REQ-031 Without the macro: no err port, no detection logic.
REQ-032 With the macro: err is registered alongside out; on capture err <= 1 if the captured i has more than one bit set, else 0; err holds while out holds; err is cleared when valid clears.

Verification
REQ-040 Reset: rst=1 for 2 cycles with en=1, i=16'hFFFF -> out=0, valid=0, err=0.
REQ-041 Fixed mode, N=16: i=16'h0012, en=1, ready=1 -> next cycle out=4, valid=1; then i=0 -> valid=0 the cycle after.
REQ-042 Backpressure: capture i=16'h0100 (out=8); ready=0, i=16'h8000 for 3 cycles -> out=8, valid=1 held; ready=1 -> next cycle out=15.
REQ-043 Round-robin (MODE=1): i=16'h8001 held, en=1, ready=1 from reset -> out sequence 0,15,0,15; ptr wraps 15 -> 0.
REQ-044 Reset mid-operation: valid=1, ready=0, rst pulsed 1 cycle -> valid=0, out=0, ptr=0; next capture of i=16'h0400 -> out=10.
REQ-045 ENC_MULTIHOT_ERR_EN defined: i=16'h0003 -> out=1, err=1; next i=16'h0004 -> out=2, err=0.
